uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 97 +++++++++
 tb/tb_uart_tx_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locked arbiter feeding four byte requesters into one UART transmitter.
// Holds the owner until its last byte and aborts a stalled packet after STALL_MAX idle cycles.
module uart_tx_arb #(
    parameter int GAP_CYCLES = 0,
    parameter int STALL_MAX  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic        abort,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;
    logic [2:0]  state;
    logic [1:0]  owner, last_owner, pick;
    logic        last_lat;
    logic [15:0] stall_cnt, stall_next;
    logic [7:0]  gap_cnt;
    assign stall_next = stall_cnt + 16'd1;
    // Scan downward so the nearest requester after last_owner wins; last_owner itself is lowest priority.
    always_comb begin
        pick = last_owner + 2'd1;
        for (int k = 4; k >= 1; k--)
            if (req_valid[last_owner + 2'(k)]) pick = last_owner + 2'(k);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            req_ready  <= '0;
            tx_wr      <= 1'b0;
            tx_data    <= '0;
            abort      <= 1'b0;
            stall_cnt  <= '0;
            gap_cnt    <= '0;
            owner      <= '0;
            last_owner <= 2'd3;
            last_lat   <= 1'b0;
        end else begin
            tx_wr     <= 1'b0;
            req_ready <= '0;
            abort     <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    owner     <= pick;
                    grant     <= 4'b0001 << pick;
                    stall_cnt <= '0;
                    state     <= SEND;
                end
                SEND: if (req_valid[owner] && !tx_busy) begin
                    tx_wr     <= 1'b1;
                    tx_data   <= req_data[{owner, 3'b000} +: 8];
                    req_ready <= grant;
                    last_lat  <= req_last[owner];
                    stall_cnt <= '0;
                    state     <= WAIT_BUSY;
                end else if (!req_valid[owner]) begin
                    if (stall_next == 16'(STALL_MAX)) begin
                        abort      <= 1'b1;
                        grant      <= '0;
                        last_owner <= owner;
                        stall_cnt  <= '0;
                        state      <= IDLE;
                    end else begin
                        stall_cnt <= stall_next;
                    end
                end
                WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
                WAIT_DONE: if (!tx_busy) begin
                    if (last_lat) begin
                        grant      <= '0;
                        last_owner <= owner;
                        gap_cnt    <= '0;
                        state      <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        state <= SEND;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= IDLE;
                    else gap_cnt <= gap_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized packets against a packet-level round-robin model,
// with a simple UART busy model and queue-driven requesters.
module tb_uart_tx_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        abort, tx_wr, tx_busy;
    logic [7:0]  tx_data;

    uart_tx_arb #(.GAP_CYCLES(2), .STALL_MAX(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .abort(abort),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int cyc = 0, bcnt = 0, busy_len = 2, bad_ready = 0;
    int abort_cnt = 0, abort_cyc = 0, fall_cyc = 0, m_last = 3;
    logic [3:0] abort_grant = 4'hF;
    logic force_busy = 1'b0;
    logic [8:0] rq [4][$];
    logic [8:0] mq [4][$];
    logic [9:0] wr_log [$];
    logic [9:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, transmitter busy model and requesters, all acting on the falling edge.
    initial forever begin
        @(negedge clk);
        if (tx_wr || |req_ready) begin
            if (!tx_wr || !$onehot(req_ready) || req_ready != grant) bad_ready++;
        end
        if (tx_wr) begin
            logic [1:0] own = 2'd0;
            for (int r = 0; r < 4; r++) if (req_ready[r]) own = 2'(r);
            wr_log.push_back({own, tx_data});
        end
        if (abort) begin
            abort_cnt++;
            abort_cyc = cyc;
            abort_grant = grant;
        end
        if (reset) bcnt = 0;
        else if (tx_wr) bcnt = (busy_len != 0) ? busy_len : int'($urandom_range(1, 5));
        else if (bcnt > 0) bcnt--;
        if (tx_busy && !(force_busy || bcnt > 0)) fall_cyc = cyc;
        tx_busy = force_busy || bcnt > 0;
        for (int r = 0; r < 4; r++) begin
            if (req_ready[r] && rq[r].size() > 0) void'(rq[r].pop_front());
            req_valid[r] = rq[r].size() > 0;
            req_data[8*r +: 8] = (rq[r].size() > 0) ? rq[r][0][7:0] : 8'($urandom);
            req_last[r] = (rq[r].size() > 0) ? rq[r][0][8] : 1'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic enq(input int r, input logic [7:0] d, input logic last);
        rq[r].push_back({last, d});
        mq[r].push_back({last, d});
    endtask

    function automatic int pend();
        return rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size();
    endfunction

    // Whole packets go out in round-robin order among requesters that still hold packets.
    task automatic predict();
        while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
            int c = -1;
            logic [8:0] b;
            for (int k = 1; k <= 4 && c < 0; k++)
                if (mq[(m_last + k) % 4].size() > 0) c = (m_last + k) % 4;
            do begin
                b = mq[c].pop_front();
                exp_q.push_back({c[1:0], b[7:0]});
            end while (!b[8] && mq[c].size() > 0);
            m_last = c;
        end
    endtask

    task automatic run_idle(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((pend() != 0 || grant != 0 || tx_busy) && n < 3000);
        repeat (4) tick();
        check({tag, "_timeout"}, 32'(n < 3000), 1);
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_count"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
        wr_log.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_tx_wr"}, tx_wr, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_abort"}, abort, 0);
    endtask

    task automatic clear_all();
        for (int r = 0; r < 4; r++) begin
            rq[r].delete();
            mq[r].delete();
        end
        wr_log.delete();
        exp_q.delete();
        m_last = 3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        int nw;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_busy = 1'b0;
        #1;
        check_reset_outs("por");
        repeat (3) tick();
        reset = 1'b0;
        tick();

        enq(2, 8'hA5, 1'b1);
        predict();
        tick();
        check("single_grant", grant, 4'b0100);
        run_idle("single");
        cmp_log("single");
        check("single_hold_data", tx_data, 8'hA5);
        check("single_grant_clear", grant, 0);

        do_reset();
        for (int i = 0; i < 5; i++) enq(order[i], 8'(8'h10 + i), 1'b1);
        predict();
        run_idle("rr");
        check("rr_count", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++)
            check($sformatf("rr_owner%0d", i), 32'(wr_log[i][9:8]), order[i]);
        cmp_log("rr");

        enq(1, 8'h31, 1'b0);
        enq(1, 8'h32, 1'b0);
        enq(1, 8'h33, 1'b1);
        enq(2, 8'h41, 1'b1);
        predict();
        run_idle("lock");
        cmp_log("lock");

        busy_len = 0;
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < 4; r++) begin
                int np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) enq(r, 8'($urandom), 1'(b == len - 1));
                end
            end
            predict();
            run_idle($sformatf("rand%0d", round));
            cmp_log($sformatf("rand%0d", round));
        end
        check("ready_protocol", bad_ready, 0);

        busy_len = 3;
        do_reset();
        enq(2, 8'h22, 1'b1);
        enq(3, 8'h33, 1'b0);
        predict();
        run_idle("stall");
        cmp_log("stall");
        check("stall_abort_cnt", abort_cnt, 1);
        check("stall_abort_delay", abort_cyc - fall_cyc, 9);
        check("stall_abort_grant", abort_grant, 0);
        repeat (20) tick();
        check("stall_no_more_wr", wr_log.size(), 0);

        force_busy = 1'b1;
        busy_len = 6;
        enq(0, 8'h5A, 1'b0);
        enq(0, 8'hC3, 1'b1);
        repeat (2) tick();
        check("busy_grant", grant, 4'b0001);
        repeat (8) tick();
        check("busy_no_wr", wr_log.size(), 0);
        force_busy = 1'b0;
        nw = 0;
        while (wr_log.size() == 0 && nw < 20) begin
            tick();
            nw++;
        end
        check("busy_release_wr", wr_log.size(), 1);
        if (wr_log.size() > 0) check("busy_release_data", wr_log[0], {2'd0, 8'h5A});
        tick();
        reset = 1'b1;
        #1;
        check_reset_outs("midreset");
        clear_all();
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("midreset_no_wr", wr_log.size(), 0);
        enq(1, 8'h11, 1'b1);
        enq(0, 8'h77, 1'b1);
        predict();
        tick();
        check("midreset_first_grant", grant, 4'b0001);
        run_idle("post");
        cmp_log("post");
        check("ready_protocol_final", bad_ready, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
